// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, clocks-per-bit helper,
// data width. Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } uart_rx_state_t;

   // Truncating divide; the fractional part of a bit period is dropped.
   function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: valid/ready byte plus error pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds parity_err_o).
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] data_o;
   logic                   valid_o;
   logic                   ready_i;
   logic                   frame_err_o;
   logic                   overrun_o;
`ifdef UART_RX_PARITY_EN
   logic                   parity_err_o;

   modport master (output data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
                   input  ready_i);
   modport slave  (input  data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
                   output ready_i);
`else
   modport master (output data_o, valid_o, frame_err_o, overrun_o,
                   input  ready_i);
   modport slave  (input  data_o, valid_o, frame_err_o, overrun_o,
                   output ready_i);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Double-register the input; both stages reset to the line idle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Bytes are presented on a valid/ready interface; framing, overrun and parity
// errors are one-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 25_000_000,
   parameter int unsigned BAUD_RATE   = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   uart_rx_if.master  bus
);

   localparam int unsigned CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int unsigned HALF      = CPB / 2;
   localparam int unsigned CNT_W     = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_W);

   logic                   w_rx_s;

   uart_rx_state_t         r_state,   w_state_nx;
   logic [CNT_W-1:0]       r_cnt,     w_cnt_nx;
   logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_nx;
   logic [UART_DATA_W-1:0] r_shift,   w_shift_nx;
   logic [UART_DATA_W-1:0] r_data,    w_data_nx;
   logic                   r_valid,   w_valid_nx;
   logic                   r_ferr,    w_ferr_nx;
   logic                   r_ovr,     w_ovr_nx;
`ifdef UART_RX_PARITY_EN
   logic                   r_par_pend, w_par_pend_nx;
   logic                   r_perr,     w_perr_nx;
`endif

   logic w_tick_half;
   logic w_tick_bit;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx_i),
      .o_q (w_rx_s)
   );

   assign w_tick_half = (r_cnt == CNT_W'(HALF - 1));
   assign w_tick_bit  = (r_cnt == CNT_W'(CPB - 1));

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_pend <= 1'b0;
         r_perr     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_bit_cnt <= w_bit_nx;
         r_shift   <= w_shift_nx;
         r_data    <= w_data_nx;
         r_valid   <= w_valid_nx;
         r_ferr    <= w_ferr_nx;
         r_ovr     <= w_ovr_nx;
`ifdef UART_RX_PARITY_EN
         r_par_pend <= w_par_pend_nx;
         r_perr     <= w_perr_nx;
`endif
      end
   end

   // Next-state and output logic; the baud counter reloads at every sample point.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_bit_nx   = r_bit_cnt;
      w_shift_nx = r_shift;
      w_data_nx  = r_data;
      w_valid_nx = r_valid && !bus.ready_i;
      w_ferr_nx  = 1'b0;
      w_ovr_nx   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_pend_nx = r_par_pend;
      w_perr_nx     = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            if (!w_rx_s) begin
               w_state_nx = ST_START;
               w_bit_nx   = '0;
`ifdef UART_RX_PARITY_EN
               w_par_pend_nx = 1'b0;
`endif
            end
         end

         ST_START: begin
            if (w_tick_half) begin
               w_cnt_nx   = '0;
               w_state_nx = w_rx_s ? ST_IDLE : ST_DATA;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (w_tick_bit) begin
               w_cnt_nx   = '0;
               w_shift_nx = {w_rx_s, r_shift[UART_DATA_W-1:1]};
               w_bit_nx   = r_bit_cnt + BIT_CNT_W'(1);
               if (r_bit_cnt == BIT_CNT_W'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nx = ST_PARITY;
`else
                  w_state_nx = ST_STOP;
`endif
               end
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_tick_bit) begin
               w_cnt_nx      = '0;
               w_par_pend_nx = ((^r_shift) != w_rx_s);
               w_state_nx    = ST_STOP;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
`endif

         ST_STOP: begin
            if (w_tick_bit) begin
               w_cnt_nx = '0;
               if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                  if (r_par_pend) w_perr_nx = 1'b1;
                  else
`endif
                  if (!r_valid || bus.ready_i) begin
                     w_data_nx  = r_shift;
                     w_valid_nx = 1'b1;
                  end else begin
                     w_ovr_nx = 1'b1;
                  end
                  w_state_nx = ST_IDLE;
               end else begin
                  w_ferr_nx  = 1'b1;
                  w_state_nx = ST_BREAK;
               end
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end

         ST_BREAK: begin
            w_cnt_nx = '0;
            if (w_rx_s) w_state_nx = ST_IDLE;
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign bus.data_o      = r_data;
   assign bus.valid_o     = r_valid;
   assign bus.frame_err_o = r_ferr;
   assign bus.overrun_o   = r_ovr;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err_o = r_perr;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the team's 8N1 UART transmitter `top`. It samples the asynchronous `rx_i` line in the 25 MHz PLL domain on the iCEBreaker and reassembles 8-bit frames, LSB first. Each frame is presented on a valid/ready byte interface for the downstream ALU command path. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- `CLK_FREQ_HZ`, 25_000_000: system clock frequency.
- `BAUD_RATE`, 115_200: line rate. CPB = CLK_FREQ_HZ/BAUD_RATE, truncated (217 at defaults). HALF = CPB/2, truncated (108).
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `rx_i` input 1: asynchronous serial line; idles high.
- `data_o` output 8: received byte. Stable while `valid_o` is high.
- `valid_o` output 1: byte available. Held high until accepted.
- `ready_i` input 1: consumer accepts the byte when `valid_o && ready_i`.
- `frame_err_o` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o` output 1: one-cycle pulse when a completed byte is dropped.
- `parity_err_o` output 1: present only with `UART_RX_PARITY_EN`. One-cycle pulse.

## Operation
- `rx_i` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer resets to 1.
- State machine states: IDLE, START, DATA, PARITY (only with `UART_RX_PARITY_EN`), STOP, BREAK.
- IDLE:
  - `rx_s` == 0 → START; bit counter cleared.
- START:
  - Count HALF cycles, then sample `rx_s`.
  - Sample is 0 → DATA. Sample is 1 → IDLE (glitch rejected; no flag).
- DATA:
  - Count CPB cycles per bit and sample at the end of each count, i.e. at mid-bit.
  - Shift the sample in at bit [7], shifting right, so the byte arrives LSB first.
  - After 8 samples → PARITY if present, else STOP.
- PARITY:
  - After CPB cycles, sample the parity bit. Even parity over the 8 data bits.
  - A mismatch sets a pending-parity-error flag. The frame continues to STOP.
- STOP: after CPB cycles, sample `rx_s`.
  - Sample 1, no pending parity error:
    - If `valid_o` == 0, or `ready_i` == 1 in this same cycle: load `data_o` and set `valid_o`.
    - Otherwise pulse `overrun_o`; the old byte is retained and the new one is dropped.
    - Next state IDLE.
  - Sample 1, pending parity error: pulse `parity_err_o`, drop the byte, → IDLE.
  - Sample 0: pulse `frame_err_o`, drop the byte, → BREAK.
- BREAK:
  - Wait for `rx_s` == 1, then → IDLE. This prevents re-triggering on a held-low line.
- The `valid_o` handshake and frame reception are independent; reception continues while `valid_o` is held.
- Reset:
  - Every output is 0: `data_o` = 8'h00, `valid_o` = 0, all error flags 0.
  - State = IDLE, counters = 0.
  - Reset asserted mid-frame abandons the frame with no flag.

## Timing
- Latency, `rx_i` falling edge to `valid_o` rising, default build: 2 + HALF + 9·CPB + 1 cycles = 2064 at defaults, ±1 for the edge phase.
- With parity: add CPB cycles.
- `valid_o` drops the cycle after `valid_o && ready_i`.
- A new byte and an acceptance completing in the same cycle: the new byte is loaded and `valid_o` stays high. This is not an overrun.
- The baud counter is ⌈log2(CPB)⌉ bits wide and reloads at each sample point. There is no cumulative drift beyond the truncation of CPB.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1.
  - The PARITY state and the `parity_err_o` port exist.
  - Pairs with a transmitter built with parity.
- Not defined:
  - Frames are 8N1.
  - No PARITY state and no `parity_err_o` port.
  - A 9th bit on the line is treated as the stop bit.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum;
  - a `clks_per_bit(freq, baud)` function;
  - the `UART_DATA_W` = 8 constant.
  These are shared with the transmitter.
- Sub-module `uart_sync2`: the 2-flop synchronizer with a reset value parameter (1 here).

## Test plan
- Send 8'hAC at 115200 baud, `ready_i` = 1.
  - → `valid_o` pulses once with `data_o` = 8'hAC, 2064 ±1 cycles after the start edge.
  - → No error flags.
- Send 8'h55 then 8'hA3 back to back, `ready_i` = 0.
  - → 8'h55 is held on `data_o` and `overrun_o` pulses once.
  - → Raising `ready_i` drops `valid_o`.
- Apply a 40-cycle low glitch on idle `rx_i`.
  - → State returns to IDLE, with no `valid_o` and no flags.
- Send 8'hFF with the stop bit forced low, then hold the line low for 5000 cycles.
  - → A single `frame_err_o` pulse and no `valid_o`.
  - → After the line returns high, 8'h12 is received correctly.
- Assert `rst` during data bit 4 of 8'hF0.
  - → All outputs 0, state IDLE.
  - → The next frame, 8'h0F, is received correctly.
- Parity build only: send 8'h07 with the parity bit = 0 (wrong; correct is 1).
  - → `parity_err_o` pulses and `valid_o` stays 0.
  - → With parity bit 1, 8'h07 is delivered.
